// File: rtl/demux1to16_deser_if.sv
// demux1to16_deser_if: serial-in / parallel-out handshake bundle for the deserializer
interface demux1to16_deser_if #(
  parameter int N  = 16,
  parameter int SW = 4
);
  logic          din;
  logic          din_valid;
  logic          frame_start;
  logic          din_ready;
  logic [SW-1:0] sel;
  logic [N-1:0]  out;
  logic          out_valid;
  logic          out_ready;
  logic          frame_err;
  modport master (
    output din, din_valid, frame_start, out_ready,
    input  din_ready, sel, out, out_valid, frame_err
  );
  modport slave (
    input  din, din_valid, frame_start, out_ready,
    output din_ready, sel, out, out_valid, frame_err
  );
endinterface

// File: rtl/demux1to16_deser.sv
// demux1to16_deser: routes each accepted serial bit to lane sel and presents
// completed N-bit words on a valid/ready output
module demux1to16_deser #(
  parameter int N  = 16,
  parameter int SW = 4
) (
  input logic               clk,
  input logic               rst_n,
  demux1to16_deser_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
  state_t        r_state;
  logic [SW-1:0] r_sel;
  logic [N-2:0]  r_buf;
  logic [N-1:0]  r_out;
  logic          r_out_valid;
  logic          r_frame_err;
  logic          w_ready;
  logic          w_acc;
  assign w_ready         = ~r_out_valid | bus.out_ready;
  assign w_acc           = bus.din_valid & w_ready;
  assign bus.din_ready   = w_ready;
  assign bus.sel         = r_sel;
  assign bus.out         = r_out;
  assign bus.out_valid   = r_out_valid;
  assign bus.frame_err   = r_frame_err;
  // the top lane never lands in r_buf: it goes straight into r_out on completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_buf       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_acc & bus.frame_start) begin
          r_buf[0] <= bus.din;
          r_sel    <= SW'(1);
          r_state  <= COLLECT;
        end
        COLLECT: if (w_acc) begin
          if (bus.frame_start) begin
            r_frame_err <= 1'b1;
            r_buf[0]    <= bus.din;
            r_sel       <= SW'(1);
          end else if (r_sel == SW'(N-1)) begin
            r_out       <= {bus.din, r_buf};
            r_out_valid <= 1'b1;
            r_sel       <= '0;
            r_state     <= HOLD;
          end else begin
            r_buf[r_sel] <= bus.din;
            r_sel        <= r_sel + SW'(1);
          end
        end
        HOLD: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          if (w_acc & bus.frame_start) begin
            r_buf[0] <= bus.din;
            r_sel    <= SW'(1);
            r_state  <= COLLECT;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_demux1to16_deser.sv
// tb_demux1to16_deser: directed scenarios plus random traffic checked against a
// queue-based frame model
module tb_demux1to16_deser;
  localparam int N  = 16;
  localparam int SW = 4;
  localparam int VW = N + SW + 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  demux1to16_deser_if #(.N(N), .SW(SW)) bus ();
  demux1to16_deser #(.N(N), .SW(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_checks = 0;
  int n_fail = 0;
  bit           q[$];
  bit           m_coll = 1'b0;
  bit           m_valid = 1'b0;
  bit           m_err = 1'b0;
  logic [N-1:0] m_out = '0;
  logic         obs_rdy;
  logic         exp_rdy;
  function automatic logic [VW-1:0] exp_v();
    return {exp_rdy, m_out, m_valid, SW'(m_coll ? q.size() : 0), m_err};
  endfunction
  function automatic logic [VW-1:0] obs_v();
    return {obs_rdy, bus.out, bus.out_valid, bus.sel, bus.frame_err};
  endfunction
  task automatic tick(input logic r, input logic d, input logic v, input logic f, input logic o);
    logic acc;
    rst_n = r; bus.din = d; bus.din_valid = v; bus.frame_start = f; bus.out_ready = o;
    #1;
    obs_rdy = bus.din_ready;
    exp_rdy = !m_valid || o;
    @(posedge clk);
    if (!r) begin
      q.delete(); m_coll = 0; m_valid = 0; m_err = 0; m_out = '0;
    end else begin
      acc = v && exp_rdy;
      if (m_valid && o) m_valid = 0;
      if (acc && f) begin
        if (m_coll) m_err = 1;
        q.delete(); q.push_back(d); m_coll = 1;
      end else if (acc && m_coll) begin
        q.push_back(d);
        if (q.size() == N) begin
          for (int i = 0; i < N; i++) m_out[i] = q[i];
          m_valid = 1; m_coll = 0; q.delete();
        end
      end
    end
    #1;
  endtask
  task automatic test_reset();
    tick(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    tick(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    n_checks++;
    if ({bus.out, bus.out_valid, bus.sel, bus.frame_err, bus.din_ready} !== {16'h0000, 1'b0, 4'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset: got out=%h v=%b sel=%0d err=%b rdy=%b", bus.out, bus.out_valid, bus.sel, bus.frame_err, bus.din_ready);
    end
  endtask
  task automatic test_basic_frame();
    logic [N-1:0] w = 16'hA5C3;
    for (int i = 0; i < N; i++) begin
      tick(1, w[i], 1, i == 0, 1);
      n_checks++;
      if (obs_v() !== exp_v() || bus.sel !== SW'((i + 1) % N)) begin
        n_fail++;
        $display("FAIL basic bit %0d: got %h exp %h sel=%0d", i, obs_v(), exp_v(), bus.sel);
      end
    end
    n_checks++;
    if (bus.out !== 16'hA5C3 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic word: got %h v=%b exp a5c3 v=1", bus.out, bus.out_valid);
    end
    tick(1, 0, 0, 0, 1);
    n_checks++;
    if (bus.out_valid !== 1'b0 || obs_v() !== exp_v()) begin
      n_fail++;
      $display("FAIL basic one-cycle valid: got v=%b exp 0", bus.out_valid);
    end
  endtask
  task automatic test_gaps_backpressure();
    logic [N-1:0] w = 16'h1234;
    int b = 0;
    for (int c = 0; b < N; c++) begin
      if (c % 3 == 2) tick(1, 1'($urandom), 0, 1'($urandom), 0);
      else begin
        tick(1, w[b], 1, b == 0, 0);
        b++;
      end
      n_checks++;
      if (obs_v() !== exp_v()) begin
        n_fail++;
        $display("FAIL gaps cycle %0d: got %h exp %h", c, obs_v(), exp_v());
      end
    end
    n_checks++;
    if (bus.out !== 16'h1234 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL gaps word: got %h v=%b exp 1234 v=1", bus.out, bus.out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1, 1'($urandom), 1, 1, 0);
      n_checks++;
      if (obs_rdy !== 1'b0 || bus.out !== 16'h1234 || bus.out_valid !== 1'b1 || bus.sel !== 4'd0) begin
        n_fail++;
        $display("FAIL backpressure %0d: got rdy=%b out=%h v=%b sel=%0d exp rdy=0 out=1234", i, obs_rdy, bus.out, bus.out_valid, bus.sel);
      end
    end
    tick(1, 1, 1, 1, 1);
    n_checks++;
    if (obs_rdy !== 1'b1 || bus.sel !== 4'd1 || bus.out_valid !== 1'b0 || obs_v() !== exp_v()) begin
      n_fail++;
      $display("FAIL release: got rdy=%b sel=%0d v=%b exp rdy=1 sel=1 v=0", obs_rdy, bus.sel, bus.out_valid);
    end
  endtask
  task automatic test_restart();
    for (int i = 0; i < 7; i++) tick(1, 1'($urandom), 1, i == 0, 1);
    for (int i = 0; i < N; i++) begin
      tick(1, 1, 1, i == 0, 0);
      n_checks++;
      if (bus.frame_err !== 1'b1 || obs_v() !== exp_v()) begin
        n_fail++;
        $display("FAIL restart bit %0d: got %h exp %h err=%b", i, obs_v(), exp_v(), bus.frame_err);
      end
    end
    n_checks++;
    if (bus.out !== 16'hFFFF || bus.out_valid !== 1'b1 || bus.frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL restart word: got %h v=%b err=%b exp ffff v=1 err=1", bus.out, bus.out_valid, bus.frame_err);
    end
  endtask
  task automatic test_idle_drop();
    logic [N-1:0] w = 16'h8001;
    tick(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      tick(1, 1'($urandom), 1, 0, 1);
      n_checks++;
      if (bus.sel !== 4'd0 || obs_v() !== exp_v()) begin
        n_fail++;
        $display("FAIL idle drop %0d: got sel=%0d exp 0", i, bus.sel);
      end
    end
    for (int i = 0; i < N; i++) tick(1, w[i], 1, i == 0, 0);
    n_checks++;
    if (bus.out !== 16'h8001 || bus.out_valid !== 1'b1 || bus.frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL idle word: got %h v=%b err=%b exp 8001 v=1 err=0", bus.out, bus.out_valid, bus.frame_err);
    end
  endtask
  task automatic test_reset_mid();
    logic [N-1:0] w = 16'h00FF;
    tick(1, 1, 1, 0, 1);
    for (int i = 0; i < 10; i++) tick(1, 1'($urandom), 1, i == 0, 1);
    tick(0, 1, 1, 0, 1);
    n_checks++;
    if ({bus.out, bus.out_valid, bus.sel, bus.frame_err, bus.din_ready} !== {16'h0000, 1'b0, 4'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL mid reset: got out=%h v=%b sel=%0d err=%b rdy=%b", bus.out, bus.out_valid, bus.sel, bus.frame_err, bus.din_ready);
    end
    for (int i = 0; i < N; i++) tick(1, w[i], 1, i == 0, 0);
    n_checks++;
    if (bus.out !== 16'h00FF || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL post reset word: got %h v=%b exp 00ff v=1", bus.out, bus.out_valid);
    end
    tick(0, 1, 1, 1, 0);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out !== 16'h0000 || obs_v() !== exp_v()) begin
      n_fail++;
      $display("FAIL hold reset: got v=%b out=%h exp v=0 out=0000", bus.out_valid, bus.out);
    end
  endtask
  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      tick($urandom_range(0, 63) != 0, 1'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 11) == 0, 1'($urandom));
      n_checks++;
      if (obs_v() !== exp_v()) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h exp %h", c, obs_v(), exp_v());
      end
    end
  endtask
  initial begin
    bus.din = 0; bus.din_valid = 0; bus.frame_start = 0; bus.out_ready = 0;
    test_reset();
    test_basic_frame();
    test_gaps_backpressure();
    test_restart();
    test_idle_drop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
